pcs_link_bringup_ctrl: RTL and testbench
========================================

Name: pcs_link_bringup_ctrl

Overview:
- Sequences the enable inputs of the PCS TX and RX chains (tx_toplevel, rx_toplevel) in the 100GbE loopback.
- Bring-up order: TX chain first, then RX block sync, then alignment, deskew, and the rest of the RX datapath.
- At each step it waits on the RX status flags, with a timeout and a bounded retry count.
- Once the link is up it monitors lock and hi-BER, and drops back to relock on loss.

Parameters:
- N_LANES, 20, number of PCS lanes.
- NB_TIMER, 16, width of the step timer.
- LOCK_TIMEOUT, 40000, cycles allowed per lock step before a timeout (must be < 2^NB_TIMER).
- SETTLE_CYCLES, 64, TX settle time, and the deskew stability window.
- MAX_RETRIES, 3, number of relock retries before FAIL.
- NB_RETRY, $clog2(MAX_RETRIES+1), width of the retry counter.
- NB_LINKDOWN_CNT, 16, width of the link-down event counter.

Ports:
- i_clock, in, 1, system clock.
- i_reset, in, 1, synchronous, active-high reset.
- i_start, in, 1, pulse; starts bring-up from IDLE or FAIL.
- i_stop, in, 1, level; forces IDLE from any state and clears all enables.
- i_block_lock, in, N_LANES, per-lane block lock from rx.
- i_am_lock, in, N_LANES, per-lane AM lock from rx.
- i_invalid_skew, in, 1, deskewer invalid-skew flag.
- i_hi_ber, in, N_LANES, per-lane hi-BER flag.
- o_tx_enables, out, 7, {valid_gen, frame_gen, encoder, clock_comp, scrambler, pc_1_20, am_insertion} (MSB first).
- o_rx_enables, out, 8, {block_sync, aligner, deskewer, lane_reorder, descrambler, clock_comp, test_pattern_checker, decoder} (MSB first).
- o_state, out, 4, current state encoding.
- o_link_up, out, 1, high in LINK_UP only.
- o_fail, out, 1, high in FAIL only.
- o_retry_count, out, NB_RETRY, retries used in the current bring-up.
- o_linkdown_count, out, NB_LINKDOWN_CNT, LINK_UP exits due to loss; saturating.

Behaviour:

Reset and general:
- One clock domain; reset is synchronous, active-high.
- On reset: state=IDLE(0), all enables 0, timer 0, retry 0, linkdown 0, o_link_up=0, o_fail=0.
- All outputs are registered. Enables change on the clock edge of the state transition, i.e. 1 cycle after the condition is sampled.
- Step timer clears on every state entry and increments each cycle while in a WAIT state. Timeout condition: timer==LOCK_TIMEOUT-1.

States and transitions:
- IDLE(0): all enables 0. On i_start go to TX_UP.
- TX_UP(1): all 7 TX enables = 1. Wait SETTLE_CYCLES cycles, then go to RX_SYNC. Clears retry count on entry from IDLE/FAIL.
- RX_SYNC(2): rx block_sync = 1.
  - &i_block_lock → RX_ALIGN.
  - Timeout → RETRY.
- RX_ALIGN(3): additionally enables aligner.
  - &i_am_lock → RX_DESKEW.
  - Loss of any block_lock → RETRY immediately.
  - Timeout → RETRY.
- RX_DESKEW(4): additionally enables deskewer.
  - Stability counter counts consecutive cycles with i_invalid_skew=0; any 1 clears it.
  - Counter reaching SETTLE_CYCLES → RX_DATA.
  - Timeout → RETRY.
- RX_DATA(5): sets the remaining 5 RX enables simultaneously, then goes to LINK_UP on the next cycle.
- LINK_UP(6): all enables 1, o_link_up=1.
  - Any of (~&i_block_lock, ~&i_am_lock, |i_hi_ber) → RELOCK, and linkdown_count+1 (saturating).
- RETRY(7): 1 cycle, all RX enables 0; TX enables held.
  - If retry_count==MAX_RETRIES → FAIL.
  - Else retry_count+1 → RX_SYNC.
- RELOCK(8): 1 cycle, all RX enables 0, retry_count cleared, → RX_SYNC.
- FAIL(9): o_fail=1. TX enables held, RX enables 0. On i_start go to TX_UP.

Priority and boundary conditions:
- Priority: i_reset > i_stop > i_start > state logic.
- i_start is ignored outside IDLE/FAIL.
- i_stop held high keeps the block in IDLE; i_start is ignored while i_stop is high.
- In RX_SYNC, lock and timeout in the same cycle: lock wins.
- Enable ordering invariant: an RX enable is never 1 while any lower-index predecessor is 0, where block_sync is index 0; "lower-index predecessor" means the enables listed before it in o_rx_enables (MSB first).
- Counters never wrap; linkdown_count saturates at all-ones.

Test Plan:
(Params for sim: LOCK_TIMEOUT=100, SETTLE_CYCLES=4, MAX_RETRIES=2.)
- Nominal bring-up: pulse i_start at cycle 10; block_lock=all-1 at cycle 30; am_lock=all-1 at cycle 50; invalid_skew=0 throughout → tx_enables=7'h7F at cycle 11, link_up by cycle ~58, rx_enables=8'hFF, retry_count=0.
- Block-lock never achieved → RX_SYNC times out 3 times; retry_count goes 1, then 2; FAIL at ~cycle 10+1+4+3×101+2; o_fail=1, rx_enables=0, tx_enables=7'h7F.
- Deskew glitch: invalid_skew pulses high every 3 cycles for 20 cycles, then stays low → RX_DATA entered exactly 4 cycles after the last pulse is released.
- In LINK_UP, set i_hi_ber[7]=1 for 1 cycle → next cycle state=RELOCK, rx_enables=0, linkdown_count=1; relock completes once locks are held.
- i_stop asserted in RX_ALIGN → next cycle state=IDLE, all enables 0. Then i_start with i_stop=0 restarts at TX_UP with retry_count=0.
- i_reset pulsed in LINK_UP → all outputs return to reset values the next cycle; linkdown_count=0.

Source files
------------

// File: rtl/pcs_link_bringup_ctrl.sv
// pcs_link_bringup_ctrl
// Sequences the PCS TX and RX chain enables for the 100GbE loopback.
// Bring-up order: TX chain, RX block sync, alignment, deskew, rest of the RX datapath.
// Each lock step has a timeout and a bounded retry count. After the link comes up,
// block lock, AM lock and hi-BER are monitored. Any loss sends the block back to relock.
//
// Ports:
//   i_clock           system clock
//   i_reset           synchronous, active-high reset
//   i_start           pulse; starts bring-up from IDLE or FAIL
//   i_stop            level; forces IDLE and clears all enables
//   i_block_lock      per-lane block lock from the RX chain
//   i_am_lock         per-lane alignment-marker lock from the RX chain
//   i_invalid_skew    deskewer invalid-skew flag
//   i_hi_ber          per-lane hi-BER flag
//   o_tx_enables      {valid_gen, frame_gen, encoder, clock_comp, scrambler, pc_1_20, am_insertion}
//   o_rx_enables      {block_sync, aligner, deskewer, lane_reorder, descrambler,
//                      clock_comp, test_pattern_checker, decoder}
//   o_state           current state encoding
//   o_link_up         high in LINK_UP only
//   o_fail            high in FAIL only
//   o_retry_count     retries used in the current bring-up
//   o_linkdown_count  saturating count of LINK_UP exits caused by loss of lock/BER
module pcs_link_bringup_ctrl #(
    parameter int N_LANES         = 20,
    parameter int NB_TIMER        = 16,
    parameter int LOCK_TIMEOUT    = 40000,
    parameter int SETTLE_CYCLES   = 64,
    parameter int MAX_RETRIES     = 3,
    parameter int NB_RETRY        = $clog2(MAX_RETRIES + 1),
    parameter int NB_LINKDOWN_CNT = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [N_LANES-1:0]         i_block_lock,
    input  logic [N_LANES-1:0]         i_am_lock,
    input  logic                       i_invalid_skew,
    input  logic [N_LANES-1:0]         i_hi_ber,
    output logic [6:0]                 o_tx_enables,
    output logic [7:0]                 o_rx_enables,
    output logic [3:0]                 o_state,
    output logic                       o_link_up,
    output logic                       o_fail,
    output logic [NB_RETRY-1:0]        o_retry_count,
    output logic [NB_LINKDOWN_CNT-1:0] o_linkdown_count
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_TX_UP     = 4'd1;
    localparam logic [3:0] ST_RX_SYNC   = 4'd2;
    localparam logic [3:0] ST_RX_ALIGN  = 4'd3;
    localparam logic [3:0] ST_RX_DESKEW = 4'd4;
    localparam logic [3:0] ST_RX_DATA   = 4'd5;
    localparam logic [3:0] ST_LINK_UP   = 4'd6;
    localparam logic [3:0] ST_RETRY     = 4'd7;
    localparam logic [3:0] ST_RELOCK    = 4'd8;
    localparam logic [3:0] ST_FAIL      = 4'd9;

    localparam int NB_STAB = $clog2(SETTLE_CYCLES + 1);

    localparam logic [NB_TIMER-1:0] TIMEOUT_LAST = NB_TIMER'(LOCK_TIMEOUT - 1);
    localparam logic [NB_TIMER-1:0] SETTLE_LAST  = NB_TIMER'(SETTLE_CYCLES - 1);
    localparam logic [NB_STAB-1:0]  STABLE_LAST  = NB_STAB'(SETTLE_CYCLES - 1);
    localparam logic [NB_RETRY-1:0] RETRY_LIMIT  = NB_RETRY'(MAX_RETRIES);

    logic [3:0]                 state_q, state_d;
    logic [NB_TIMER-1:0]        timer_q, timer_d;
    logic [NB_STAB-1:0]         stab_q, stab_d;
    logic [NB_RETRY-1:0]        retry_q, retry_d;
    logic [NB_LINKDOWN_CNT-1:0] linkdown_q, linkdown_d;
    logic [6:0]                 tx_en_q, tx_en_d;
    logic [7:0]                 rx_en_q, rx_en_d;
    logic                       link_up_q, link_up_d;
    logic                       fail_q, fail_d;

    logic all_block;
    logic all_am;
    logic any_hi_ber;
    logic timed_out;
    logic wait_state;

    assign all_block  = &i_block_lock;
    assign all_am     = &i_am_lock;
    assign any_hi_ber = |i_hi_ber;
    assign timed_out  = (timer_q == TIMEOUT_LAST);
    assign wait_state = (state_q == ST_TX_UP) || (state_q == ST_RX_SYNC) ||
                        (state_q == ST_RX_ALIGN) || (state_q == ST_RX_DESKEW);

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        linkdown_d = linkdown_q;

        if (i_stop) begin
            state_d = ST_IDLE;
        end else if (i_start && ((state_q == ST_IDLE) || (state_q == ST_FAIL))) begin
            state_d = ST_TX_UP;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_TX_UP: begin
                    if (timer_q == SETTLE_LAST) state_d = ST_RX_SYNC;
                end
                // A lock that arrives on the timeout cycle still counts as success.
                ST_RX_SYNC: begin
                    if (all_block)      state_d = ST_RX_ALIGN;
                    else if (timed_out) state_d = ST_RETRY;
                end
                // Block lock must hold while alignment is being acquired.
                ST_RX_ALIGN: begin
                    if (!all_block)     state_d = ST_RETRY;
                    else if (all_am)    state_d = ST_RX_DESKEW;
                    else if (timed_out) state_d = ST_RETRY;
                end
                // The cycle that brings the clean-skew run up to SETTLE_CYCLES completes deskew.
                ST_RX_DESKEW: begin
                    if (!i_invalid_skew && (stab_q == STABLE_LAST)) state_d = ST_RX_DATA;
                    else if (timed_out)                             state_d = ST_RETRY;
                end
                ST_RX_DATA: begin
                    state_d = ST_LINK_UP;
                end
                ST_LINK_UP: begin
                    if (!all_block || !all_am || any_hi_ber) begin
                        state_d = ST_RELOCK;
                        retry_d = '0;
                        if (linkdown_q != '1) linkdown_d = linkdown_q + NB_LINKDOWN_CNT'(1);
                    end
                end
                ST_RETRY: begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RX_SYNC;
                        retry_d = retry_q + NB_RETRY'(1);
                    end
                end
                ST_RELOCK: begin
                    state_d = ST_RX_SYNC;
                    retry_d = '0;
                end
                ST_IDLE, ST_FAIL: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Both counters restart on every state change. The step timer runs only in the wait states.
    // The stability counter tracks the run of clean-skew cycles during deskew.
    always_comb begin
        timer_d = '0;
        stab_d  = '0;
        if ((state_d == state_q) && wait_state) timer_d = timer_q + NB_TIMER'(1);
        if ((state_q == ST_RX_DESKEW) && (state_d == ST_RX_DESKEW) && !i_invalid_skew)
            stab_d = stab_q + NB_STAB'(1);
    end

    // Outputs are decoded from the next state and then registered.
    // As a result, they change on the same edge as the state.
    always_comb begin
        tx_en_d   = (state_d == ST_IDLE) ? 7'h00 : 7'h7F;
        link_up_d = (state_d == ST_LINK_UP);
        fail_d    = (state_d == ST_FAIL);
        case (state_d)
            ST_RX_SYNC:             rx_en_d = 8'h80;
            ST_RX_ALIGN:            rx_en_d = 8'hC0;
            ST_RX_DESKEW:           rx_en_d = 8'hE0;
            ST_RX_DATA, ST_LINK_UP: rx_en_d = 8'hFF;
            default:                rx_en_d = 8'h00;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            stab_q     <= '0;
            retry_q    <= '0;
            linkdown_q <= '0;
            tx_en_q    <= '0;
            rx_en_q    <= '0;
            link_up_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stab_q     <= stab_d;
            retry_q    <= retry_d;
            linkdown_q <= linkdown_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            link_up_q  <= link_up_d;
            fail_q     <= fail_d;
        end
    end

    assign o_state          = state_q;
    assign o_tx_enables     = tx_en_q;
    assign o_rx_enables     = rx_en_q;
    assign o_link_up        = link_up_q;
    assign o_fail           = fail_q;
    assign o_retry_count    = retry_q;
    assign o_linkdown_count = linkdown_q;

endmodule

// File: tb/tb_pcs_link_bringup_ctrl.sv
// Testbench for pcs_link_bringup_ctrl.
// Randomized lock delays, lanes and glitch lengths are driven through a directed bring-up story.
// Expected states and counts come from the bring-up rules and the timing parameters.
module tb_pcs_link_bringup_ctrl;

    localparam int N_LANES         = 20;
    localparam int NB_TIMER        = 16;
    localparam int LOCK_TIMEOUT    = 100;
    localparam int SETTLE_CYCLES   = 4;
    localparam int MAX_RETRIES     = 2;
    localparam int NB_RETRY        = $clog2(MAX_RETRIES + 1);
    localparam int NB_LINKDOWN_CNT = 16;

    localparam logic [3:0] S_IDLE = 4'd0, S_TX_UP = 4'd1, S_SYNC = 4'd2, S_ALIGN = 4'd3,
                           S_DESKEW = 4'd4, S_DATA = 4'd5, S_UP = 4'd6, S_RETRY = 4'd7,
                           S_RELOCK = 4'd8, S_FAIL = 4'd9;
    localparam logic [6:0] TX_ON = 7'h7F;
    localparam logic [N_LANES-1:0] ALL_LANES = '1;
    localparam logic [N_LANES-1:0] NO_LANES  = '0;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start, stop, skew;
    logic [N_LANES-1:0]         blk, am, hb;
    logic [6:0]                 o_tx_enables;
    logic [7:0]                 o_rx_enables;
    logic [3:0]                 o_state;
    logic                       o_link_up, o_fail;
    logic [NB_RETRY-1:0]        o_retry_count;
    logic [NB_LINKDOWN_CNT-1:0] o_linkdown_count;

    int compared   = 0;
    int mismatched = 0;
    int retry_exp  = 0;
    int ld_exp     = 0;

    pcs_link_bringup_ctrl #(
        .N_LANES(N_LANES), .NB_TIMER(NB_TIMER), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES), .MAX_RETRIES(MAX_RETRIES),
        .NB_RETRY(NB_RETRY), .NB_LINKDOWN_CNT(NB_LINKDOWN_CNT)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
        .i_block_lock(blk), .i_am_lock(am), .i_invalid_skew(skew), .i_hi_ber(hb),
        .o_tx_enables(o_tx_enables), .o_rx_enables(o_rx_enables), .o_state(o_state),
        .o_link_up(o_link_up), .o_fail(o_fail), .o_retry_count(o_retry_count),
        .o_linkdown_count(o_linkdown_count)
    );

    always #5 clk = ~clk;

    // RX enables switch on in MSB-first order, so k enabled stages form a mask from the top.
    function automatic logic [7:0] rxMask(input int k);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < k; i++) m[7-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [N_LANES-1:0] partialLanes();
        logic [N_LANES-1:0] v;
        int idx;
        v   = N_LANES'($urandom);
        idx = int'($urandom_range(N_LANES - 1, 0));
        v[idx] = 1'b0;
        return v;
    endfunction

    task automatic applyStimulus(input logic st, input logic sp, input logic [N_LANES-1:0] b,
                                 input logic [N_LANES-1:0] a, input logic sk,
                                 input logic [N_LANES-1:0] h);
        start = st; stop = sp; blk = b; am = a; skew = sk; hb = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] st, input logic [6:0] tx,
                            input logic [7:0] rx);
        checkOutput({tag, ".state"},    32'(o_state),          32'(st));
        checkOutput({tag, ".tx"},       32'(o_tx_enables),     32'(tx));
        checkOutput({tag, ".rx"},       32'(o_rx_enables),     32'(rx));
        checkOutput({tag, ".link_up"},  32'(o_link_up),        32'(st == S_UP));
        checkOutput({tag, ".fail"},     32'(o_fail),           32'(st == S_FAIL));
        checkOutput({tag, ".retry"},    32'(o_retry_count),    32'(retry_exp));
        checkOutput({tag, ".linkdown"}, 32'(o_linkdown_count), 32'(ld_exp));
    endtask

    // Bring the link up from RX_SYNC when both lock sets are already stable and skew is clean.
    task automatic relockToUp(input string tag);
        tick(); checkAll({tag, ".align"},  S_ALIGN,  TX_ON, rxMask(2));
        tick(); checkAll({tag, ".deskew"}, S_DESKEW, TX_ON, rxMask(3));
        ticks(SETTLE_CYCLES - 1);
        checkAll({tag, ".settling"}, S_DESKEW, TX_ON, rxMask(3));
        tick(); checkAll({tag, ".data"},   S_DATA,   TX_ON, rxMask(8));
        tick(); checkAll({tag, ".up"},     S_UP,     TX_ON, rxMask(8));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_LANES-1:0] part;
        logic [N_LANES-1:0] lane_hb;
        int d;
        int m;

        // Reset and idle
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, NO_LANES, NO_LANES, 1'b0, NO_LANES);
        ticks(3);
        checkAll("reset", S_IDLE, 7'h00, 8'h00);
        rst = 1'b0;
        ticks(5);
        checkAll("idle", S_IDLE, 7'h00, 8'h00);

        // Nominal bring-up with random lock delays and partial locks while waiting
        applyStimulus(1'b1, 1'b0, NO_LANES, NO_LANES, 1'b0, NO_LANES);
        tick(); checkAll("start", S_TX_UP, TX_ON, 8'h00);
        applyStimulus(1'b0, 1'b0, NO_LANES, NO_LANES, 1'b0, NO_LANES);
        ticks(SETTLE_CYCLES - 1);
        checkAll("txSettle", S_TX_UP, TX_ON, 8'h00);
        tick(); checkAll("rxSync", S_SYNC, TX_ON, rxMask(1));

        part = partialLanes();
        applyStimulus(1'b1, 1'b0, part, partialLanes(), 1'b0, NO_LANES);
        tick();
        applyStimulus(1'b0, 1'b0, part, partialLanes(), 1'b0, NO_LANES);
        d = int'($urandom_range(60, 5));
        ticks(d - 1);
        checkAll("syncWait", S_SYNC, TX_ON, rxMask(1));
        applyStimulus(1'b0, 1'b0, ALL_LANES, partialLanes(), 1'b0, NO_LANES);
        tick(); checkAll("align", S_ALIGN, TX_ON, rxMask(2));
        ticks(int'($urandom_range(40, 1)));
        checkAll("alignWait", S_ALIGN, TX_ON, rxMask(2));
        applyStimulus(1'b0, 1'b0, ALL_LANES, ALL_LANES, 1'b0, NO_LANES);
        tick(); checkAll("deskew", S_DESKEW, TX_ON, rxMask(3));

        // Skew glitch every third cycle, so the clean run never reaches the window
        m = int'($urandom_range(6, 2));
        for (int i = 0; i <= 3 * m; i++) begin
            skew = ((i % 3) == 0);
            tick();
        end
        checkAll("glitch", S_DESKEW, TX_ON, rxMask(3));
        skew = 1'b0;
        ticks(SETTLE_CYCLES - 1);
        checkAll("stableAlmost", S_DESKEW, TX_ON, rxMask(3));
        tick(); checkAll("rxData", S_DATA, TX_ON, rxMask(8));
        tick(); checkAll("linkUp", S_UP, TX_ON, rxMask(8));
        ticks(int'($urandom_range(10, 1)));
        checkAll("linkHold", S_UP, TX_ON, rxMask(8));

        // One-cycle hi-BER on a random lane
        lane_hb = '0;
        lane_hb[int'($urandom_range(N_LANES - 1, 0))] = 1'b1;
        applyStimulus(1'b0, 1'b0, ALL_LANES, ALL_LANES, 1'b0, lane_hb);
        tick(); ld_exp = 1;
        checkAll("hiBerRelock", S_RELOCK, TX_ON, 8'h00);
        applyStimulus(1'b0, 1'b0, ALL_LANES, ALL_LANES, 1'b0, NO_LANES);
        tick(); checkAll("relockSync", S_SYNC, TX_ON, rxMask(1));
        relockToUp("relock1");

        // AM lock loss, then stop while stuck in alignment
        applyStimulus(1'b0, 1'b0, ALL_LANES, partialLanes(), 1'b0, NO_LANES);
        tick(); ld_exp = 2;
        checkAll("amLoss", S_RELOCK, TX_ON, 8'h00);
        tick(); checkAll("amLossSync", S_SYNC, TX_ON, rxMask(1));
        tick(); checkAll("amLossAlign", S_ALIGN, TX_ON, rxMask(2));
        ticks(int'($urandom_range(20, 1)));
        checkAll("alignStuck", S_ALIGN, TX_ON, rxMask(2));
        stop = 1'b1;
        tick(); checkAll("stop", S_IDLE, 7'h00, 8'h00);
        start = 1'b1;
        ticks(3);
        checkAll("stopBeatsStart", S_IDLE, 7'h00, 8'h00);
        stop = 1'b0;
        tick(); retry_exp = 0;
        checkAll("restart", S_TX_UP, TX_ON, 8'h00);

        // Block lock never complete: every attempt times out, ending in FAIL
        applyStimulus(1'b0, 1'b0, partialLanes(), NO_LANES, 1'b0, NO_LANES);
        ticks(SETTLE_CYCLES - 1);
        tick(); checkAll("toSync", S_SYNC, TX_ON, rxMask(1));
        for (int r = 0; r <= MAX_RETRIES; r++) begin
            ticks(LOCK_TIMEOUT - 1);
            checkAll("syncBeforeTimeout", S_SYNC, TX_ON, rxMask(1));
            tick(); checkAll("retry", S_RETRY, TX_ON, 8'h00);
            tick();
            if (r < MAX_RETRIES) begin
                retry_exp++;
                checkAll("retrySync", S_SYNC, TX_ON, rxMask(1));
            end else begin
                checkAll("fail", S_FAIL, TX_ON, 8'h00);
            end
        end
        ticks(3);
        checkAll("failHold", S_FAIL, TX_ON, 8'h00);

        // Restart from FAIL, with the lock arriving on the timeout cycle itself
        start = 1'b1;
        tick(); retry_exp = 0;
        checkAll("failRestart", S_TX_UP, TX_ON, 8'h00);
        start = 1'b0;
        ticks(SETTLE_CYCLES);
        checkAll("sync2", S_SYNC, TX_ON, rxMask(1));
        ticks(LOCK_TIMEOUT - 1);
        blk = ALL_LANES;
        tick(); checkAll("lockWinsTimeout", S_ALIGN, TX_ON, rxMask(2));

        // Block lock dropping during alignment retries immediately
        blk = partialLanes();
        tick(); checkAll("alignBlockLoss", S_RETRY, TX_ON, 8'h00);
        blk = ALL_LANES;
        am  = ALL_LANES;
        tick(); retry_exp = 1;
        checkAll("alignRetrySync", S_SYNC, TX_ON, rxMask(1));
        relockToUp("afterRetry");

        // Reset in LINK_UP clears everything, including the link-down counter
        rst = 1'b1;
        tick(); retry_exp = 0; ld_exp = 0;
        checkAll("resetUp", S_IDLE, 7'h00, 8'h00);
        rst = 1'b0;
        tick(); checkAll("postReset", S_IDLE, 7'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
